// File: rtl/friscv_rd_arbiter.sv
// Round-robin writeback arbiter: ALU, memfy and CSR rd writes share one registered regfile port.
// Optional grant counters are enabled with `define FRISCV_RDARB_STATS_EN.
module friscv_rd_arbiter #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned RV32E = 0
) (
   input  logic                aclk,
   input  logic                aresetn,
   input  logic                srst,
   input  logic                alu_valid,
   output logic                alu_ready,
   input  logic [4:0]          alu_addr,
   input  logic [XLEN-1:0]     alu_val,
   input  logic [XLEN/8-1:0]   alu_strb,
   input  logic                memfy_valid,
   output logic                memfy_ready,
   input  logic [4:0]          memfy_addr,
   input  logic [XLEN-1:0]     memfy_val,
   input  logic [XLEN/8-1:0]   memfy_strb,
   input  logic                csr_valid,
   output logic                csr_ready,
   input  logic [4:0]          csr_addr,
   input  logic [XLEN-1:0]     csr_val,
   output logic                rd_wr,
   output logic [4:0]          rd_addr,
   output logic [XLEN-1:0]     rd_val,
   output logic [XLEN/8-1:0]   rd_strb,
`ifdef FRISCV_RDARB_STATS_EN
   output logic [31:0]         alu_grants,
   output logic [31:0]         memfy_grants,
   output logic [31:0]         csr_grants,
`endif
   output logic                illegal
);

   localparam int unsigned SW = XLEN / 8;

   logic [1:0]        r_ptr;
   logic              r_wr;
   logic [4:0]        r_addr;
   logic [XLEN-1:0]   r_val;
   logic [SW-1:0]     r_strb;
   logic              r_illegal;

   logic [2:0]        w_valid;
   logic [2:0]        w_grant;
   logic              w_any;
   logic [1:0]        w_idx;
   logic [1:0]        w_ptr_d;
   logic [4:0]        w_addr;
   logic [XLEN-1:0]   w_val;
   logic [SW-1:0]     w_strb;
   logic              w_oob;
   logic              w_write;
   logic              w_illegal;

   // Round-robin pick: scan pointer, pointer+1, pointer+2 (mod 3)
   always_comb begin
      logic [2:0] sum;
      logic [1:0] k;
      w_valid = {csr_valid, memfy_valid, alu_valid} & {3{aresetn & ~srst}};
      w_grant = 3'b000;
      w_any   = 1'b0;
      w_idx   = 2'd0;
      for (int i = 0; i < 3; i++) begin
         sum = {1'b0, r_ptr} + 3'(i);
         k   = (sum >= 3'd3) ? 2'(sum - 3'd3) : sum[1:0];
         if (!w_any && w_valid[k]) begin
            w_any      = 1'b1;
            w_grant[k] = 1'b1;
            w_idx      = k;
         end
      end
   end

   assign alu_ready   = w_grant[0];
   assign memfy_ready = w_grant[1];
   assign csr_ready   = w_grant[2];

   always_comb begin
      w_addr = alu_addr;
      w_val  = alu_val;
      w_strb = alu_strb;
      case (w_idx)
         2'd1: begin
            w_addr = memfy_addr;
            w_val  = memfy_val;
            w_strb = memfy_strb;
         end
         2'd2: begin
            w_addr = csr_addr;
            w_val  = csr_val;
            w_strb = {SW{1'b1}};
         end
         default: ;
      endcase
   end

   // x0 grants are consumed silently; RV32E drops x16..x31 and flags them
   assign w_oob     = (RV32E != 0) && w_addr[4];
   assign w_write   = w_any && (w_addr != 5'd0) && !w_oob;
   assign w_illegal = w_any && w_oob;

   always_comb begin
      w_ptr_d = r_ptr;
      if (w_any) begin
         w_ptr_d = (w_idx == 2'd2) ? 2'd0 : w_idx + 2'd1;
      end
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_ptr     <= 2'd0;
         r_wr      <= 1'b0;
         r_addr    <= 5'd0;
         r_val     <= '0;
         r_strb    <= '0;
         r_illegal <= 1'b0;
      end else if (srst) begin
         r_ptr     <= 2'd0;
         r_wr      <= 1'b0;
         r_addr    <= 5'd0;
         r_val     <= '0;
         r_strb    <= '0;
         r_illegal <= 1'b0;
      end else begin
         r_ptr     <= w_ptr_d;
         r_wr      <= w_write;
         r_illegal <= w_illegal;
         if (w_write) begin
            r_addr <= w_addr;
            r_val  <= w_val;
            r_strb <= w_strb;
         end
      end
   end

   assign rd_wr   = r_wr;
   assign rd_addr = r_addr;
   assign rd_val  = r_val;
   assign rd_strb = r_strb;
   assign illegal = r_illegal;

`ifdef FRISCV_RDARB_STATS_EN
   logic [31:0] r_alu_cnt;
   logic [31:0] r_memfy_cnt;
   logic [31:0] r_csr_cnt;

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_alu_cnt   <= 32'd0;
         r_memfy_cnt <= 32'd0;
         r_csr_cnt   <= 32'd0;
      end else if (srst) begin
         r_alu_cnt   <= 32'd0;
         r_memfy_cnt <= 32'd0;
         r_csr_cnt   <= 32'd0;
      end else begin
         if (w_grant[0]) r_alu_cnt   <= r_alu_cnt + 32'd1;
         if (w_grant[1]) r_memfy_cnt <= r_memfy_cnt + 32'd1;
         if (w_grant[2]) r_csr_cnt   <= r_csr_cnt + 32'd1;
      end
   end

   assign alu_grants   = r_alu_cnt;
   assign memfy_grants = r_memfy_cnt;
   assign csr_grants   = r_csr_cnt;
`endif

endmodule

// File: tb/tb_friscv_rd_arbiter.sv
// Directed bench for friscv_rd_arbiter: one RV32I and one RV32E instance share the same stimulus.
module tb_friscv_rd_arbiter;

   localparam int XLEN = 32;

   logic              aclk = 1'b0;
   logic              aresetn;
   logic              srst;
   logic              alu_valid, memfy_valid, csr_valid;
   logic [4:0]        alu_addr, memfy_addr, csr_addr;
   logic [XLEN-1:0]   alu_val, memfy_val, csr_val;
   logic [3:0]        alu_strb, memfy_strb;

   logic              alu_ready, memfy_ready, csr_ready;
   logic              rd_wr, illegal;
   logic [4:0]        rd_addr;
   logic [XLEN-1:0]   rd_val;
   logic [3:0]        rd_strb;

   logic              e_alu_ready, e_memfy_ready, e_csr_ready;
   logic              e_rd_wr, e_illegal;
   logic [4:0]        e_rd_addr;
   logic [XLEN-1:0]   e_rd_val;
   logic [3:0]        e_rd_strb;

`ifdef FRISCV_RDARB_STATS_EN
   logic [31:0] alu_grants, memfy_grants, csr_grants;
   logic [31:0] e_alu_grants, e_memfy_grants, e_csr_grants;
`endif

   int n_chk  = 0;
   int n_pass = 0;

   friscv_rd_arbiter #(.XLEN(XLEN), .RV32E(0)) dut (
      .aclk        (aclk),
      .aresetn     (aresetn),
      .srst        (srst),
      .alu_valid   (alu_valid),
      .alu_ready   (alu_ready),
      .alu_addr    (alu_addr),
      .alu_val     (alu_val),
      .alu_strb    (alu_strb),
      .memfy_valid (memfy_valid),
      .memfy_ready (memfy_ready),
      .memfy_addr  (memfy_addr),
      .memfy_val   (memfy_val),
      .memfy_strb  (memfy_strb),
      .csr_valid   (csr_valid),
      .csr_ready   (csr_ready),
      .csr_addr    (csr_addr),
      .csr_val     (csr_val),
      .rd_wr       (rd_wr),
      .rd_addr     (rd_addr),
      .rd_val      (rd_val),
      .rd_strb     (rd_strb),
`ifdef FRISCV_RDARB_STATS_EN
      .alu_grants  (alu_grants),
      .memfy_grants(memfy_grants),
      .csr_grants  (csr_grants),
`endif
      .illegal     (illegal)
   );

   friscv_rd_arbiter #(.XLEN(XLEN), .RV32E(1)) dut_e (
      .aclk        (aclk),
      .aresetn     (aresetn),
      .srst        (srst),
      .alu_valid   (alu_valid),
      .alu_ready   (e_alu_ready),
      .alu_addr    (alu_addr),
      .alu_val     (alu_val),
      .alu_strb    (alu_strb),
      .memfy_valid (memfy_valid),
      .memfy_ready (e_memfy_ready),
      .memfy_addr  (memfy_addr),
      .memfy_val   (memfy_val),
      .memfy_strb  (memfy_strb),
      .csr_valid   (csr_valid),
      .csr_ready   (e_csr_ready),
      .csr_addr    (csr_addr),
      .csr_val     (csr_val),
      .rd_wr       (e_rd_wr),
      .rd_addr     (e_rd_addr),
      .rd_val      (e_rd_val),
      .rd_strb     (e_rd_strb),
`ifdef FRISCV_RDARB_STATS_EN
      .alu_grants  (e_alu_grants),
      .memfy_grants(e_memfy_grants),
      .csr_grants  (e_csr_grants),
`endif
      .illegal     (e_illegal)
   );

   always #5 aclk = ~aclk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge aclk);
      #1;
   endtask

   task automatic idle();
      alu_valid   = 1'b0;
      memfy_valid = 1'b0;
      csr_valid   = 1'b0;
   endtask

   function automatic logic [31:0] rdy();
      return {29'd0, csr_ready, memfy_ready, alu_ready};
   endfunction

   initial begin
      logic [31:0] exp_val [3];
      logic [3:0]  exp_strb [3];
      exp_val  = '{32'hA, 32'hB, 32'hC};
      exp_strb = '{4'h3, 4'h5, 4'hF};

      aresetn = 1'b1;
      srst    = 1'b0;
      idle();
      alu_addr = 5'd3;  alu_val = '0;   alu_strb = 4'hF;
      memfy_addr = 5'd0; memfy_val = '0; memfy_strb = 4'h0;
      csr_addr = 5'd0;  csr_val = '0;
      #2 aresetn = 1'b0;
      alu_valid = 1'b1;
      #1;
      chk("rst_ready", rdy(), 32'd0);
      chk("rst_rd_wr", 32'(rd_wr), 32'd0);
      chk("rst_rd_addr", 32'(rd_addr), 32'd0);
      chk("rst_rd_val", rd_val, 32'd0);
      chk("rst_rd_strb", 32'(rd_strb), 32'd0);
      chk("rst_illegal", 32'(illegal), 32'd0);
      step();
      step();
      idle();
      aresetn = 1'b1;
      step();

      // Single ALU write
      alu_valid = 1'b1; alu_addr = 5'd5; alu_val = 32'hDEADBEEF; alu_strb = 4'hF;
      #1 chk("t1_ready", rdy(), 32'b001);
      step();
      idle();
      chk("t1_rd_wr", 32'(rd_wr), 32'd1);
      chk("t1_rd_addr", 32'(rd_addr), 32'd5);
      chk("t1_rd_val", rd_val, 32'hDEADBEEF);
      chk("t1_rd_strb", 32'(rd_strb), 32'hF);
      step();
      chk("t1_rd_wr_off", 32'(rd_wr), 32'd0);
      chk("t1_hold_addr", 32'(rd_addr), 32'd5);
      chk("t1_hold_val", rd_val, 32'hDEADBEEF);

      // srst clears outputs and the pointer
      srst = 1'b1;
      step();
      srst = 1'b0;
      chk("srst_rd_addr", 32'(rd_addr), 32'd0);
      chk("srst_rd_val", rd_val, 32'd0);

      // All three requesting: ALU, memfy, CSR, repeated
      alu_valid = 1'b1;   alu_addr = 5'd1;   alu_val = 32'hA;   alu_strb = 4'h3;
      memfy_valid = 1'b1; memfy_addr = 5'd2; memfy_val = 32'hB; memfy_strb = 4'h5;
      csr_valid = 1'b1;   csr_addr = 5'd3;   csr_val = 32'hC;
      for (int c = 0; c < 6; c++) begin
         #1 chk($sformatf("rr%0d_ready", c), rdy(), 32'(1 << (c % 3)));
         step();
         if (c == 5) idle();
         chk($sformatf("rr%0d_wr", c), 32'(rd_wr), 32'd1);
         chk($sformatf("rr%0d_addr", c), 32'(rd_addr), 32'((c % 3) + 1));
         chk($sformatf("rr%0d_val", c), rd_val, exp_val[c % 3]);
         chk($sformatf("rr%0d_strb", c), 32'(rd_strb), 32'(exp_strb[c % 3]));
      end
      step();
      chk("rr_end_wr", 32'(rd_wr), 32'd0);

      // CSR to x0 is consumed silently, then memfy to x7
      csr_valid = 1'b1; csr_addr = 5'd0; csr_val = 32'h55;
      #1 chk("x0_ready", rdy(), 32'b100);
      step();
      chk("x0_rd_wr", 32'(rd_wr), 32'd0);
      chk("x0_illegal", 32'(illegal), 32'd0);
      csr_valid = 1'b0;
      memfy_valid = 1'b1; memfy_addr = 5'd7; memfy_val = 32'h77; memfy_strb = 4'hF;
      #1 chk("x0_next_ready", rdy(), 32'b010);
      step();
      idle();
      chk("x7_rd_wr", 32'(rd_wr), 32'd1);
      chk("x7_rd_addr", 32'(rd_addr), 32'd7);
      chk("x7_rd_val", rd_val, 32'h77);

      // Zero strobe still writes
      alu_valid = 1'b1; alu_addr = 5'd4; alu_val = 32'h12345678; alu_strb = 4'h0;
      #1 chk("zs_ready", rdy(), 32'b001);
      step();
      idle();
      chk("zs_rd_wr", 32'(rd_wr), 32'd1);
      chk("zs_rd_addr", 32'(rd_addr), 32'd4);
      chk("zs_rd_strb", 32'(rd_strb), 32'd0);

      // Out-of-range address: dropped on RV32E, written on RV32I
      alu_valid = 1'b1; alu_addr = 5'd20; alu_val = 32'h20; alu_strb = 4'hF;
      #1 chk("e20_ready", 32'(e_alu_ready), 32'd1);
      step();
      idle();
      chk("e20_rd_wr", 32'(e_rd_wr), 32'd0);
      chk("e20_illegal", 32'(e_illegal), 32'd1);
      chk("i20_rd_wr", 32'(rd_wr), 32'd1);
      chk("i20_rd_addr", 32'(rd_addr), 32'd20);
      chk("i20_illegal", 32'(illegal), 32'd0);
      step();
      chk("e20_illegal_off", 32'(e_illegal), 32'd0);
      alu_valid = 1'b1; alu_addr = 5'd15; alu_val = 32'h15;
      #1 chk("e15_ready", 32'(e_alu_ready), 32'd1);
      step();
      idle();
      chk("e15_rd_wr", 32'(e_rd_wr), 32'd1);
      chk("e15_rd_addr", 32'(e_rd_addr), 32'd15);
      chk("e15_illegal", 32'(e_illegal), 32'd0);

      // srst with requests pending: no readies, then pointer back at ALU
      srst = 1'b1;
      memfy_valid = 1'b1; memfy_addr = 5'd9; memfy_val = 32'h99; memfy_strb = 4'hF;
      alu_valid = 1'b1;   alu_addr = 5'd11;  alu_val = 32'h11;  alu_strb = 4'h3;
      for (int c = 0; c < 2; c++) begin
         #1 chk($sformatf("sr%0d_ready", c), rdy(), 32'd0);
         step();
         chk($sformatf("sr%0d_rd_wr", c), 32'(rd_wr), 32'd0);
      end
      srst = 1'b0;
      #1 chk("sr_ptr_alu", rdy(), 32'b001);
      step();
      alu_valid = 1'b0;
      chk("sr_alu_wr", 32'(rd_wr), 32'd1);
      chk("sr_alu_addr", 32'(rd_addr), 32'd11);
      #1 chk("sr_memfy_ready", rdy(), 32'b010);
      step();
      idle();
      chk("sr_memfy_addr", 32'(rd_addr), 32'd9);
      chk("sr_memfy_val", rd_val, 32'h99);

      // Same address from CSR then ALU: grant order preserved
      alu_valid = 1'b1; alu_addr = 5'd6; alu_val = 32'hA1; alu_strb = 4'h3;
      csr_valid = 1'b1; csr_addr = 5'd6; csr_val = 32'hC1;
      #1 chk("ba_ready0", rdy(), 32'b100);
      step();
      csr_valid = 1'b0;
      chk("ba_first_val", rd_val, 32'hC1);
      chk("ba_first_strb", 32'(rd_strb), 32'hF);
      step();
      idle();
      chk("ba_second_val", rd_val, 32'hA1);
      chk("ba_second_strb", 32'(rd_strb), 32'h3);

`ifdef FRISCV_RDARB_STATS_EN
      srst = 1'b1;
      step();
      srst = 1'b0;
      alu_valid = 1'b1; alu_addr = 5'd2;
      repeat (10) step();
      alu_valid = 1'b0;
      csr_valid = 1'b1; csr_addr = 5'd0;
      repeat (3) step();
      csr_valid = 1'b0;
      chk("st_alu", alu_grants, 32'd10);
      chk("st_memfy", memfy_grants, 32'd0);
      chk("st_csr", csr_grants, 32'd3);
      srst = 1'b1;
      step();
      srst = 1'b0;
      chk("st_clr_alu", alu_grants, 32'd0);
      chk("st_clr_csr", csr_grants, 32'd0);
`endif

      step();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
